// File: rtl/button_bank.sv
// button_bank -- bank of N_CH independent debounced push-button channels.
//
// Each channel does the following, in order:
//   - synchronises the raw button level through two flops;
//   - debounces it: a level change is accepted after DEBOUNCE_CYCLES
//     consecutive cycles that disagree with the current debounced level;
//   - issues a one-cycle press strobe on each accepted 0->1 change;
//   - drives an OFF/ON LED state machine;
//   - keeps a saturating press counter.
//
// Configuration macro BUTTON_BANK_TOGGLE_EN:
//   - defined:   mode[i]=1 makes channel i toggle its LED on every press.
//   - undefined: every channel latches ON, and no toggle logic is built.
//
// Ports:
//   clk          - rising-edge clock
//   reset        - asynchronous reset, active low
//   button_in    - [N_CH] raw button levels, 1 = pressed
//   clear        - [N_CH] synchronous per-channel clear of LED and counter
//   mode         - [N_CH] 0 = latch, 1 = toggle (toggle build only)
//   led_status   - [N_CH] LED state per channel
//   press_pulse  - [N_CH] one-cycle strobe per accepted press
//   press_count  - [N_CH*CNT_W] saturating press counters,
//                  channel i at [i*CNT_W +: CNT_W]
//   any_led      - registered OR of led_status

module button_bank_lane #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             button_in,
    input  logic             clear,
`ifdef BUTTON_BANK_TOGGLE_EN
    input  logic             mode,
`endif
    output logic             led,
    output logic             pulse,
    output logic [CNT_W-1:0] count
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0]    DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {OFF = 1'b0, ON = 1'b1} led_state_t;

    logic [1:0]    sync_pipe;
    logic          stable;
    logic          stable_d;
    logic [DW-1:0] db_cnt;
    logic          press;
    led_state_t    state, state_nx;

    // sync_pipe[1] is the synchronised level; nothing else samples button_in.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_pipe <= '0;
            stable    <= 1'b0;
            stable_d  <= 1'b0;
            db_cnt    <= '0;
        end else begin
            sync_pipe <= {sync_pipe[0], button_in};
            stable_d  <= stable;
            if (sync_pipe[1] == stable) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                // This is the DEBOUNCE_CYCLES-th disagreeing cycle: accept it.
                stable <= sync_pipe[1];
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DW'(1);
            end
        end
    end

    // A press is the cycle after stable rises; releases are ignored.
    assign press = stable & ~stable_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= OFF;
            pulse <= 1'b0;
            count <= '0;
        end else begin
            state <= state_nx;
            pulse <= press;
            if (clear)
                count <= '0;
            else if (press && count != CNT_MAX)
                count <= count + CNT_W'(1);
        end
    end

    always_comb begin
        state_nx = state;
        if (press) begin
`ifdef BUTTON_BANK_TOGGLE_EN
            state_nx = (mode && state == ON) ? OFF : ON;
`else
            state_nx = ON;
`endif
        end
        // Clear takes priority over a coincident press. The strobe above
        // still fires for that press.
        if (clear)
            state_nx = OFF;
    end

    assign led = (state == ON);

endmodule

module button_bank #(
    parameter int N_CH            = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_CH-1:0]       button_in,
    input  logic [N_CH-1:0]       clear,
    input  logic [N_CH-1:0]       mode,
    output logic [N_CH-1:0]       led_status,
    output logic [N_CH-1:0]       press_pulse,
    output logic [N_CH*CNT_W-1:0] press_count,
    output logic                  any_led
);
`ifndef BUTTON_BANK_TOGGLE_EN
    // In the latch-only build, mode has no effect.
    logic unused_mode;
    assign unused_mode = ^mode;
`endif

    for (genvar i = 0; i < N_CH; i++) begin : g_lane
        button_bank_lane #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .button_in (button_in[i]),
            .clear     (clear[i]),
`ifdef BUTTON_BANK_TOGGLE_EN
            .mode      (mode[i]),
`endif
            .led       (led_status[i]),
            .pulse     (press_pulse[i]),
            .count     (press_count[i*CNT_W +: CNT_W])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            any_led <= 1'b0;
        else
            any_led <= |led_status;
    end

endmodule

// File: tb/tb_button_bank.sv
// Directed bench for button_bank.
//
// Instances:
//   dut  - default parameters (N_CH=4, DEBOUNCE_CYCLES=4, CNT_W=8).
//   dut2 - N_CH=1, CNT_W=2, used for the saturation and clear-vs-press cases.
//
// Expected values are hand-derived, with the LED rising on edge 7 of a held
// press. The toggle expectations follow BUTTON_BANK_TOGGLE_EN.

module tb_button_bank;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  button_in, clear, mode;
    logic [3:0]  led_status, press_pulse;
    logic [31:0] press_count;
    logic        any_led;

    logic [0:0]  b2_button, b2_clear, b2_mode;
    logic [0:0]  b2_led, b2_pulse;
    logic [1:0]  b2_count;
    logic        b2_any;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    button_bank #(.N_CH(4), .DEBOUNCE_CYCLES(4), .CNT_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .button_in   (button_in),
        .clear       (clear),
        .mode        (mode),
        .led_status  (led_status),
        .press_pulse (press_pulse),
        .press_count (press_count),
        .any_led     (any_led)
    );

    button_bank #(.N_CH(1), .DEBOUNCE_CYCLES(4), .CNT_W(2)) dut2 (
        .clk         (clk),
        .reset       (reset),
        .button_in   (b2_button),
        .clear       (b2_clear),
        .mode        (b2_mode),
        .led_status  (b2_led),
        .press_pulse (b2_pulse),
        .press_count (b2_count),
        .any_led     (b2_any)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges; return 1 time unit after the last one.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Hold a press for 8 edges, then release and let the release settle.
    task automatic press(input int ch);
        button_in[ch] = 1'b1;
        cyc(8);
        button_in[ch] = 1'b0;
        cyc(8);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [2:0] exp_led3;
        logic       prev_any;

`ifdef BUTTON_BANK_TOGGLE_EN
        exp_led3 = 3'b101;
`else
        exp_led3 = 3'b111;
`endif
        reset     = 1'b0;
        button_in = '0;
        clear     = '0;
        mode      = 4'b1000;
        b2_button = '0;
        b2_clear  = '0;
        b2_mode   = '0;

        // Reset state
        cyc(2);
        chk("rst_led",   32'(led_status),  32'h0);
        chk("rst_pulse", 32'(press_pulse), 32'h0);
        chk("rst_count", press_count,      32'h0);
        chk("rst_any",   32'(any_led),     32'h0);
        reset = 1'b1;
        cyc(2);

        // ch0 held high: LED and pulse rise on edge 7
        button_in[0] = 1'b1;
        cyc(6);
        chk("lat_e6_led",   32'(led_status[0]),  32'h0);
        chk("lat_e6_pulse", 32'(press_pulse[0]), 32'h0);
        cyc(1);
        chk("lat_e7_led",   32'(led_status[0]),  32'h1);
        chk("lat_e7_pulse", 32'(press_pulse[0]), 32'h1);
        chk("lat_e7_cnt",   32'(press_count[7:0]), 32'h1);
        chk("lat_e7_any",   32'(any_led),        32'h0);
        cyc(1);
        chk("lat_e8_pulse", 32'(press_pulse[0]), 32'h0);
        chk("lat_e8_any",   32'(any_led),        32'h1);
        button_in[0] = 1'b0;
        cyc(8);
        chk("rel_led",   32'(led_status[0]),   32'h1);
        chk("rel_cnt",   32'(press_count[7:0]), 32'h1);

        // ch1 glitch of 3 cycles is rejected
        button_in[1] = 1'b1;
        cyc(3);
        button_in[1] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cyc(1);
            chk("glitch_pulse", 32'(press_pulse[1]), 32'h0);
        end
        chk("glitch_led", 32'(led_status[1]),     32'h0);
        chk("glitch_cnt", 32'(press_count[15:8]), 32'h0);

        // ch2 latch: press, release, press, then clear
        press(2);
        chk("l2_led1", 32'(led_status[2]),      32'h1);
        chk("l2_cnt1", 32'(press_count[23:16]), 32'h1);
        press(2);
        chk("l2_led2", 32'(led_status[2]),      32'h1);
        chk("l2_cnt2", 32'(press_count[23:16]), 32'h2);
        clear[2] = 1'b1;
        cyc(1);
        clear[2] = 1'b0;
        chk("l2_clr_led", 32'(led_status[2]),      32'h0);
        chk("l2_clr_cnt", 32'(press_count[23:16]), 32'h0);

        // ch3 with mode=1: clear ch0 first so any_led follows ch3 alone
        clear[0] = 1'b1;
        cyc(1);
        clear[0] = 1'b0;
        cyc(1);
        chk("clr0_any", 32'(any_led), 32'h0);
        for (int p = 0; p < 3; p++) begin
            prev_any = any_led;
            button_in[3] = 1'b1;
            cyc(7);
            chk("tog_led",     32'(led_status[3]), 32'(exp_led3[p]));
            chk("tog_any_old", 32'(any_led),       32'(prev_any));
            cyc(1);
            chk("tog_any_new", 32'(any_led),       32'(exp_led3[p]));
            chk("tog_pulse0",  32'(press_pulse[3]), 32'h0);
            button_in[3] = 1'b0;
            cyc(8);
        end
        chk("tog_cnt", 32'(press_count[31:24]), 32'h3);

        // Reset while ch0 is mid-debounce and led_status = 1010
        press(1);
        chk("pre_rst_led", 32'(led_status), 32'hA);
        button_in[0] = 1'b1;
        cyc(4);
        reset = 1'b0;
        #2;
        chk("arst_led",   32'(led_status),  32'h0);
        chk("arst_pulse", 32'(press_pulse), 32'h0);
        chk("arst_count", press_count,      32'h0);
        chk("arst_any",   32'(any_led),     32'h0);
        button_in = '0;
        cyc(2);
        reset = 1'b1;
        for (int k = 0; k < 12; k++) begin
            cyc(1);
            chk("post_rst_pulse", 32'(press_pulse), 32'h0);
        end
        chk("post_rst_led", 32'(led_status), 32'h0);

        // dut2 with CNT_W=2: five presses saturate at 3
        for (int p = 0; p < 5; p++) begin
            b2_button = 1'b1;
            cyc(7);
            chk("sat_pulse", 32'(b2_pulse), 32'h1);
            chk("sat_cnt",   32'(b2_count), (p < 3) ? 32'(p + 1) : 32'h3);
            b2_button = 1'b0;
            cyc(9);
        end

        // Clear coincident with a press: clear wins, the strobe still fires
        b2_button = 1'b1;
        cyc(6);
        b2_clear = 1'b1;
        cyc(1);
        b2_clear = 1'b0;
        chk("clrp_pulse", 32'(b2_pulse), 32'h1);
        chk("clrp_led",   32'(b2_led),   32'h0);
        chk("clrp_cnt",   32'(b2_count), 32'h0);
        cyc(1);
        chk("clrp_pulse_end", 32'(b2_pulse), 32'h0);
        b2_button = 1'b0;
        cyc(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
